// File: rtl/leds7_pkg.sv
// leds7_pkg: shared types, ASCII constants and hex decoding for the 7-segment command path.
package leds7_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [7:0] ASCII_START = 8'h23;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISCARD
    } state_e;

    // Returns {valid, nibble}; valid is 0 for any byte outside 0-9, A-F, a-f.
    function automatic logic [4:0] ascii_hex_to_nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, 4'(c - 8'h30)};
        else if (c >= 8'h41 && c <= 8'h46)
            r = {1'b1, 4'(c - 8'h37)};
        else if (c >= 8'h61 && c <= 8'h66)
            r = {1'b1, 4'(c - 8'h57)};
        return r;
    endfunction

endpackage

// File: rtl/leds7_cmd_parser.sv
// leds7_cmd_parser: assembles "#<hex><CR|LF>" frames from a byte stream and commits them
// atomically to a registered digit/blank image, flagging framing errors and timeouts.
module leds7_cmd_parser
    import leds7_pkg::*;
#(
    parameter int CLK_FREQ   = 50,
    parameter int NUM_DIGITS = 4,
    parameter int TIMEOUT_US = 10000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tdata,
    input  logic                          tvalid,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]         blank,
    output logic                          update,
    output logic                          err,
    output logic [7:0]                    err_cnt
);

    localparam int W     = DIGIT_W * NUM_DIGITS;
    localparam int T     = TIMEOUT_US * CLK_FREQ;
    localparam int TW    = (T > 1) ? $clog2(T) : 1;
    localparam int CW    = $clog2(NUM_DIGITS + 1);

    state_e              state_q, state_d;
    logic [W-1:0]        sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [W-1:0]        digits_q;
    logic [NUM_DIGITS-1:0] blank_q;
    logic                update_q, err_q;
    logic [7:0]          err_cnt_q;
    logic                commit_d, err_d;

    logic [4:0] hex;
    logic       is_start, is_term, is_hex, tmo_hit;

    assign hex      = ascii_hex_to_nib(tdata);
    assign is_hex   = hex[4];
    assign is_start = tdata == ASCII_START;
    assign is_term  = tdata == ASCII_CR || tdata == ASCII_LF;
    assign tmo_hit  = state_q != S_IDLE && tmo_q == TW'(T - 1);

    always_comb begin
        state_d    = state_q;
        sh_dig_d   = sh_dig_q;
        sh_blank_d = sh_blank_q;
        cnt_d      = cnt_q;
        commit_d   = 1'b0;
        err_d      = 1'b0;
        tmo_d      = tmo_q + TW'(1);
        if (tvalid) begin
            tmo_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (is_start) begin
                        sh_dig_d   = '0;
                        sh_blank_d = '1;
                        cnt_d      = '0;
                        state_d    = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (is_start) begin
                        sh_dig_d   = '0;
                        sh_blank_d = '1;
                        cnt_d      = '0;
                    end else if (is_term) begin
                        commit_d = 1'b1;
                        state_d  = S_IDLE;
                    end else if (is_hex && cnt_q != CW'(NUM_DIGITS)) begin
                        // Shift in at digit 0 so short frames end up right-aligned.
                        sh_dig_d   = (sh_dig_q << DIGIT_W) | W'(hex[3:0]);
                        sh_blank_d = sh_blank_q << 1;
                        cnt_d      = cnt_q + CW'(1);
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (is_start) begin
                        sh_dig_d   = '0;
                        sh_blank_d = '1;
                        cnt_d      = '0;
                        state_d    = S_COLLECT;
                    end else if (is_term) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_hit) begin
            err_d   = state_q == S_COLLECT;
            state_d = S_IDLE;
        end
        if (state_d == S_IDLE)
            tmo_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sh_dig_q   <= '0;
            sh_blank_q <= '1;
            cnt_q      <= '0;
            tmo_q      <= '0;
            digits_q   <= '0;
            blank_q    <= '1;
            update_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sh_dig_q   <= sh_dig_d;
            sh_blank_q <= sh_blank_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            update_q   <= commit_d;
            err_q      <= err_d;
            if (commit_d) begin
                digits_q <= sh_dig_q;
                blank_q  <= sh_blank_q;
            end
            if (err_d && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign digits  = digits_q;
    assign blank   = blank_q;
    assign update  = update_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_leds7_cmd_parser.sv
// tb_leds7_cmd_parser: directed scenarios for the hex frame parser with hand-computed expectations.
module tb_leds7_cmd_parser;

    localparam int UART_GAP = 433;
    localparam int TMO      = 5000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  tdata = 8'h00;
    logic        tvalid = 1'b0;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        update, err;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int upd_n = 0, err_n = 0, dbl_n = 0;
    int cyc = 0, byte_cyc = 0, err_cyc = 0;
    logic prev_upd = 1'b0, prev_err = 1'b0;
    logic last_err, last_upd;

    leds7_cmd_parser #(.CLK_FREQ(50), .NUM_DIGITS(4), .TIMEOUT_US(100)) dut (
        .clk(clk), .reset(reset), .tdata(tdata), .tvalid(tvalid),
        .digits(digits), .blank(blank), .update(update), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tvalid) byte_cyc <= cyc;
    end

    always @(negedge clk) begin
        if (update) upd_n++;
        if (err) begin
            err_n++;
            err_cyc = cyc - 1;
        end
        if ((update && prev_upd) || (err && prev_err)) dbl_n++;
        prev_upd = update;
        prev_err = err;
    end

    task automatic send_str(input string s, input int gap);
        @(negedge clk);
        for (int i = 0; i < s.len(); i++) begin
            tdata  = s[i];
            tvalid = 1'b1;
            @(negedge clk);
            tvalid   = 1'b0;
            last_err = err;
            last_upd = update;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp += 5;
        if (digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits got %h want 0000", digits); end
        if (blank !== 4'hF) begin n_fail++; $display("FAIL reset_blank got %b want 1111", blank); end
        if (update !== 1'b0) begin n_fail++; $display("FAIL reset_update got %b want 0", update); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int u0;
        u0 = upd_n;
        send_str("#1a2F\015", UART_GAP);
        n_cmp += 5;
        if (last_upd !== 1'b1) begin n_fail++; $display("FAIL basic_update_latency got %b want 1", last_upd); end
        if (upd_n - u0 != 1) begin n_fail++; $display("FAIL basic_update_count got %0d want 1", upd_n - u0); end
        if (digits !== 16'h1A2F) begin n_fail++; $display("FAIL basic_digits got %h want 1a2f", digits); end
        if (blank !== 4'b0000) begin n_fail++; $display("FAIL basic_blank got %b want 0000", blank); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_short;
        send_str("#7\n", UART_GAP);
        n_cmp += 2;
        if (digits !== 16'h0007) begin n_fail++; $display("FAIL short_digits got %h want 0007", digits); end
        if (blank !== 4'b1110) begin n_fail++; $display("FAIL short_blank got %b want 1110", blank); end
        send_str("#\015", UART_GAP);
        n_cmp += 2;
        if (blank !== 4'b1111) begin n_fail++; $display("FAIL empty_blank got %b want 1111", blank); end
        if (digits !== 16'h0000) begin n_fail++; $display("FAIL empty_digits got %h want 0000", digits); end
    endtask

    task automatic test_overflow;
        int u0;
        u0 = upd_n;
        send_str("#12345", UART_GAP);
        n_cmp++;
        if (last_err !== 1'b1) begin n_fail++; $display("FAIL overflow_err_at_5 got %b want 1", last_err); end
        send_str("\015", UART_GAP);
        n_cmp += 4;
        if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL overflow_err_cnt got %0d want 1", err_cnt); end
        if (upd_n != u0) begin n_fail++; $display("FAIL overflow_no_update got %0d want 0", upd_n - u0); end
        if (digits !== 16'h0000) begin n_fail++; $display("FAIL overflow_digits_kept got %h want 0000", digits); end
        if (blank !== 4'b1111) begin n_fail++; $display("FAIL overflow_blank_kept got %b want 1111", blank); end
        send_str("#99\015", UART_GAP);
        n_cmp += 2;
        if (digits !== 16'h0099) begin n_fail++; $display("FAIL after_overflow_digits got %h want 0099", digits); end
        if (blank !== 4'b1100) begin n_fail++; $display("FAIL after_overflow_blank got %b want 1100", blank); end
    endtask

    task automatic test_bad_char;
        int u0;
        u0 = upd_n;
        send_str("#1G", UART_GAP);
        n_cmp++;
        if (last_err !== 1'b1) begin n_fail++; $display("FAIL badchar_err_at_G got %b want 1", last_err); end
        send_str("\015", UART_GAP);
        n_cmp += 3;
        if (upd_n != u0) begin n_fail++; $display("FAIL badchar_no_update got %0d want 0", upd_n - u0); end
        if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL badchar_err_cnt got %0d want 2", err_cnt); end
        if (digits !== 16'h0099) begin n_fail++; $display("FAIL badchar_digits_kept got %h want 0099", digits); end
        send_str("#12#34\015", UART_GAP);
        n_cmp += 3;
        if (digits !== 16'h0034) begin n_fail++; $display("FAIL restart_digits got %h want 0034", digits); end
        if (blank !== 4'b1100) begin n_fail++; $display("FAIL restart_blank got %b want 1100", blank); end
        if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL restart_err_cnt got %0d want 2", err_cnt); end
    endtask

    task automatic test_timeout;
        int u0, e0;
        e0 = err_n;
        send_str("#12", 0);
        repeat (6000) @(negedge clk);
        n_cmp += 3;
        if (err_n - e0 != 1) begin n_fail++; $display("FAIL timeout_err_pulses got %0d want 1", err_n - e0); end
        if (err_cyc - byte_cyc != TMO) begin n_fail++; $display("FAIL timeout_latency got %0d want %0d", err_cyc - byte_cyc, TMO); end
        if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL timeout_err_cnt got %0d want 3", err_cnt); end
        u0 = upd_n;
        send_str("3\015", UART_GAP);
        n_cmp += 3;
        if (upd_n != u0) begin n_fail++; $display("FAIL timeout_tail_update got %0d want 0", upd_n - u0); end
        if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL timeout_tail_err_cnt got %0d want 3", err_cnt); end
        if (digits !== 16'h0034) begin n_fail++; $display("FAIL timeout_digits_kept got %h want 0034", digits); end
    endtask

    task automatic test_reset_mid;
        int u0;
        send_str("#12", UART_GAP);
        #1 reset = 1'b1;
        #1;
        n_cmp += 3;
        if (digits !== 16'h0000) begin n_fail++; $display("FAIL async_reset_digits got %h want 0000", digits); end
        if (blank !== 4'hF) begin n_fail++; $display("FAIL async_reset_blank got %b want 1111", blank); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL async_reset_err_cnt got %0d want 0", err_cnt); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        u0 = upd_n;
        send_str("34\015", UART_GAP);
        n_cmp++;
        if (upd_n != u0) begin n_fail++; $display("FAIL post_reset_tail_update got %0d want 0", upd_n - u0); end
        send_str("#5\015", UART_GAP);
        n_cmp += 2;
        if (digits !== 16'h0005) begin n_fail++; $display("FAIL post_reset_digits got %h want 0005", digits); end
        if (blank !== 4'b1110) begin n_fail++; $display("FAIL post_reset_blank got %b want 1110", blank); end
    endtask

    task automatic test_back_to_back;
        int u0;
        u0 = upd_n;
        send_str("#BEEF\015", 0);
        @(negedge clk);
        n_cmp += 3;
        if (digits !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_digits got %h want beef", digits); end
        if (blank !== 4'b0000) begin n_fail++; $display("FAIL b2b_blank got %b want 0000", blank); end
        if (upd_n - u0 != 1) begin n_fail++; $display("FAIL b2b_update_count got %0d want 1", upd_n - u0); end
        send_str("#1G#AB\n", 0);
        @(negedge clk);
        n_cmp += 3;
        if (digits !== 16'h00AB) begin n_fail++; $display("FAIL discard_restart_digits got %h want 00ab", digits); end
        if (blank !== 4'b1100) begin n_fail++; $display("FAIL discard_restart_blank got %b want 1100", blank); end
        if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL discard_restart_err_cnt got %0d want 1", err_cnt); end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 260; i++) send_str("#G", 0);
        send_str("\015", 2);
        n_cmp += 2;
        if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL saturate_err_cnt got %0d want 255", err_cnt); end
        if (dbl_n != 0) begin n_fail++; $display("FAIL pulse_width_doubles got %0d want 0", dbl_n); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_short;
        test_overflow;
        test_bad_char;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        test_saturate;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
